// File: rtl/scan_tick_controller.sv
// Display scan sequencer: programmable tick enable plus digit-multiplex FSM with
// a blanking gap between digits. The divisor is reprogrammed via a four-phase handshake.
module scan_tick_controller #(
    parameter int unsigned DIV_DEFAULT = 5000,
    parameter int unsigned DIV_W       = 32,
    parameter int unsigned DIGITS      = 4,
    parameter int unsigned BLANK_CYC   = 16
) (
    input  logic              inputclk,
    input  logic              rst,
    input  logic              enable,
    input  logic              cfg_req,
    input  logic [DIV_W-1:0]  cfg_div,
    output logic              cfg_ack,
    output logic              tick,
    output logic [1:0]        digit_sel,
    output logic [DIGITS-1:0] anode,
    output logic              blank
);

    // A period of at least BLANK_CYC+2 guarantees the FSM is back in SHOW before the next tick.
    localparam logic [DIV_W-1:0] MIN_DIV = DIV_W'(BLANK_CYC + 2);
    localparam logic [DIV_W-1:0] RST_DIV = (DIV_W'(DIV_DEFAULT) < MIN_DIV) ? MIN_DIV : DIV_W'(DIV_DEFAULT);
    localparam int unsigned BC_W = (BLANK_CYC < 2) ? 1 : $clog2(BLANK_CYC);
    localparam logic [BC_W-1:0] BC_LAST  = BC_W'(BLANK_CYC - 1);
    localparam logic [1:0]      LAST_DIG = 2'(DIGITS - 1);

    typedef enum logic {SHOW, BLANK} state_t;

    logic [DIV_W-1:0] r_count, r_div, r_pend_div;
    logic             r_pending, r_armed, r_tick, r_ack;
    state_t           r_state, w_state_nxt;
    logic [1:0]       r_digit, w_digit_nxt;
    logic [BC_W-1:0]  r_bcnt, w_bcnt_nxt;

    logic             w_wrap, w_capture, w_apply;
    logic [DIV_W-1:0] w_clamped;

    assign w_wrap    = enable && (r_count == r_div - DIV_W'(1));
    assign w_capture = !r_pending && r_armed && cfg_req;
    // Enabled: swap only on a wrap so the old period completes; disabled: swap at once.
    assign w_apply   = r_pending && (w_wrap || !enable);
    assign w_clamped = (cfg_div < MIN_DIV) ? MIN_DIV : cfg_div;

    always_ff @(posedge inputclk or negedge rst) begin
        if (!rst) begin
            r_count    <= '0;
            r_div      <= RST_DIV;
            r_pend_div <= '0;
            r_pending  <= 1'b0;
            r_armed    <= 1'b1;
            r_tick     <= 1'b0;
            r_ack      <= 1'b0;
        end else begin
            r_tick <= w_wrap;
            r_ack  <= w_apply;
            if (w_apply) begin
                r_div     <= r_pend_div;
                r_pending <= 1'b0;
            end
            if (w_capture) begin
                r_pend_div <= w_clamped;
                r_pending  <= 1'b1;
            end
            if (!cfg_req)
                r_armed <= 1'b1;
            else if (w_capture)
                r_armed <= 1'b0;
            if (w_wrap || (w_apply && !enable))
                r_count <= '0;
            else if (enable)
                r_count <= r_count + DIV_W'(1);
        end
    end

    always_ff @(posedge inputclk or negedge rst) begin
        if (!rst) begin
            r_state <= SHOW;
            r_digit <= 2'd0;
            r_bcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_digit <= w_digit_nxt;
            r_bcnt  <= w_bcnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_digit_nxt = r_digit;
        w_bcnt_nxt  = r_bcnt;
        if (enable) begin
            case (r_state)
                SHOW: begin
                    if (r_tick) begin
                        w_state_nxt = BLANK;
                        w_bcnt_nxt  = '0;
                    end
                end
                BLANK: begin
                    if (r_bcnt == BC_LAST) begin
                        w_state_nxt = SHOW;
                        w_digit_nxt = (r_digit == LAST_DIG) ? 2'd0 : r_digit + 2'd1;
                    end else begin
                        w_bcnt_nxt = r_bcnt + BC_W'(1);
                    end
                end
                default: w_state_nxt = SHOW;
            endcase
        end
    end

    always_comb begin
        anode = '1;
        for (int i = 0; i < int'(DIGITS); i++)
            anode[i] = !((r_state == SHOW) && (r_digit == 2'(i)));
    end

    assign blank     = (r_state == BLANK);
    assign digit_sel = r_digit;
    assign tick      = r_tick;
    assign cfg_ack   = r_ack;

endmodule

// File: tb/tb_scan_tick_controller.sv
// Directed bench for scan_tick_controller: per-cycle comparison against a behavioural
// model, plus hand-computed checks at specific edges counted from reset release.
module tb_scan_tick_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b1;
    logic        cfg_req = 1'b0;
    logic [31:0] cfg_div = '0;
    logic        cfg_ack, tick, blank;
    logic [1:0]  digit_sel;
    logic [3:0]  anode;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int ecount   = 0;

    always #5 clk = ~clk;

    scan_tick_controller #(
        .DIV_DEFAULT(20), .DIV_W(32), .DIGITS(4), .BLANK_CYC(4)
    ) dut (
        .inputclk (clk),
        .rst      (rst),
        .enable   (enable),
        .cfg_req  (cfg_req),
        .cfg_div  (cfg_div),
        .cfg_ack  (cfg_ack),
        .tick     (tick),
        .digit_sel(digit_sel),
        .anode    (anode),
        .blank    (blank)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h (edge %0d, t=%0t)", name, act, exp, ecount, $time);
    endtask

    // Rising edges since reset release.
    always @(posedge clk or negedge rst) begin
        if (!rst) ecount = 0;
        else      ecount = ecount + 1;
    end

    // Behavioural model: period arithmetic, pending divisor as -1/value, blank as countdown.
    int m_count, m_div, m_pend, m_blank_left, m_digit, old_pend;
    bit m_armed, m_tick, m_ack, was_tick;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_count = 0; m_div = 20; m_pend = -1; m_armed = 1;
            m_tick = 0; m_ack = 0; m_digit = 0; m_blank_left = 0;
        end else begin
            old_pend = m_pend;
            was_tick = m_tick;
            m_tick = 0;
            m_ack  = 0;
            if (enable) begin
                if (m_blank_left > 0) begin
                    m_blank_left--;
                    if (m_blank_left == 0) m_digit = (m_digit + 1) % 4;
                end else if (was_tick) begin
                    m_blank_left = 4;
                end
                if (m_count == m_div - 1) begin
                    m_count = 0;
                    m_tick  = 1;
                    if (old_pend >= 0) begin m_div = old_pend; m_pend = -1; m_ack = 1; end
                end else begin
                    m_count++;
                end
            end else if (old_pend >= 0) begin
                m_div = old_pend; m_pend = -1; m_count = 0; m_ack = 1;
            end
            if (!cfg_req) m_armed = 1;
            else if (old_pend < 0 && m_armed) begin
                m_pend  = (cfg_div < 6) ? 6 : int'(cfg_div);
                m_armed = 0;
            end
        end
    end

    always @(negedge clk) begin
        logic [3:0] exp_an;
        exp_an = (m_blank_left > 0) ? 4'hF : (4'hF & ~(4'b0001 << m_digit));
        chk("tick", {31'd0, tick}, {31'd0, m_tick});
        chk("cfg_ack", {31'd0, cfg_ack}, {31'd0, m_ack});
        chk("anode", {28'd0, anode}, {28'd0, exp_an});
        chk("digit_sel", {30'd0, digit_sel}, 32'(m_digit));
        chk("blank", {31'd0, blank}, {31'd0, (m_blank_left > 0)});
        chk("tick_in_blank", {31'd0, tick & blank}, 32'd0);
    end

    task automatic goto(input int e);
        int guard = 0;
        while (ecount < e && guard < 2000) begin
            @(posedge clk); #2;
            guard++;
        end
        chk("reach_edge", 32'(ecount), 32'(e));
    endtask

    initial begin
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_anode", {28'd0, anode}, 32'hE);
        chk("rst_tick", {31'd0, tick}, 32'd0);
        chk("rst_blank", {31'd0, blank}, 32'd0);
        chk("rst_sel", {30'd0, digit_sel}, 32'd0);
        rst = 1'b1;

        // Free run and scan sequence
        goto(19);  chk("t19", {31'd0, tick}, 32'd0);
        goto(20);  chk("t20", {31'd0, tick}, 32'd1);
        goto(21);  chk("t21", {31'd0, tick}, 32'd0); chk("an21", {28'd0, anode}, 32'hF);
        goto(24);  chk("an24", {28'd0, anode}, 32'hF);
        goto(25);  chk("an25", {28'd0, anode}, 32'hD); chk("sel25", {30'd0, digit_sel}, 32'd1);
        goto(40);  chk("t40", {31'd0, tick}, 32'd1);
        goto(45);  chk("an45", {28'd0, anode}, 32'hB); chk("sel45", {30'd0, digit_sel}, 32'd2);
        goto(60);  chk("t60", {31'd0, tick}, 32'd1);
        goto(65);  chk("an65", {28'd0, anode}, 32'h7); chk("sel65", {30'd0, digit_sel}, 32'd3);
        goto(85);  chk("an85", {28'd0, anode}, 32'hE); chk("sel85", {30'd0, digit_sel}, 32'd0);

        // Mid-period reprogram at count 7
        goto(107); cfg_req = 1'b1; cfg_div = 32'd10;
        goto(119); chk("ack119", {31'd0, cfg_ack}, 32'd0);
        goto(120); chk("ack120", {31'd0, cfg_ack}, 32'd1); chk("t120", {31'd0, tick}, 32'd1);
        cfg_req = 1'b0;
        goto(130); chk("t130", {31'd0, tick}, 32'd1);
        goto(140); chk("t140", {31'd0, tick}, 32'd1);

        // Clamp: 3 then 0 both give period 6
        cfg_req = 1'b1; cfg_div = 32'd3;
        goto(150); chk("ack150", {31'd0, cfg_ack}, 32'd1); chk("t150", {31'd0, tick}, 32'd1);
        cfg_req = 1'b0;
        goto(155); chk("t155", {31'd0, tick}, 32'd0);
        goto(156); chk("t156", {31'd0, tick}, 32'd1);
        goto(162); chk("t162", {31'd0, tick}, 32'd1);
        cfg_req = 1'b1; cfg_div = 32'd0;
        goto(168); chk("ack168", {31'd0, cfg_ack}, 32'd1); chk("t168", {31'd0, tick}, 32'd1);
        cfg_req = 1'b0;
        goto(174); chk("t174", {31'd0, tick}, 32'd1);

        // Reset mid-blank with a divisor pending
        cfg_req = 1'b1; cfg_div = 32'd8;
        goto(176); chk("blank176", {31'd0, blank}, 32'd1);
        #1 rst = 1'b0; cfg_req = 1'b0;
        #1;
        chk("arst_anode", {28'd0, anode}, 32'hE);
        chk("arst_blank", {31'd0, blank}, 32'd0);
        chk("arst_sel", {30'd0, digit_sel}, 32'd0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        goto(19);  chk("r19", {31'd0, tick}, 32'd0);
        goto(20);  chk("r20", {31'd0, tick}, 32'd1); chk("rack20", {31'd0, cfg_ack}, 32'd0);
        goto(40);  chk("r40", {31'd0, tick}, 32'd1);

        // Disabled config at count 12
        goto(52);  enable = 1'b0;
        goto(53);  cfg_req = 1'b1; cfg_div = 32'd8;
        goto(54);  chk("dack54", {31'd0, cfg_ack}, 32'd0);
        goto(55);  chk("dack55", {31'd0, cfg_ack}, 32'd1); chk("dt55", {31'd0, tick}, 32'd0);
        cfg_req = 1'b0;
        goto(60);  chk("dt60", {31'd0, tick}, 32'd0);
        enable = 1'b1;
        goto(67);  chk("dt67", {31'd0, tick}, 32'd0);
        goto(68);  chk("dt68", {31'd0, tick}, 32'd1);
        goto(76);  chk("dt76", {31'd0, tick}, 32'd1);
        goto(90);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/scan_tick_controller.md
# scan_tick_controller

Sequencing controller for the calculator's seven-segment display scan. It replaces a free-running divided clock with a single-cycle tick enable on the system clock. The tick period is a divisor that requesters can reprogram through a four-phase handshake, applied glitch-free at period boundaries. The block also runs the digit-multiplex state machine, with a blanking interval between digits, which drives the anode lines and digit select for the display datapath.

## Interface
- `DIV_DEFAULT`, 5000: tick period in `inputclk` cycles after reset.
- `DIV_W`, 32: width of the period counter and the divisor.
- `DIGITS`, 4: number of multiplexed digits. Range 2..4.
- `BLANK_CYC`, 16: number of cycles all anodes are off between digits.
- `inputclk`, in, 1: system clock. All state updates on the rising edge.
- `rst`, in, 1: reset, asynchronous, active-low. Asserting `rst` = 0 clears all state immediately.
- `enable`, in, 1: run/hold control for the period counter and scan FSM.
- `cfg_req`, in, 1: divisor change request, four-phase.
- `cfg_div`, in, `DIV_W`: requested period. Must be stable while `cfg_req` = 1.
- `cfg_ack`, out, 1: one-cycle pulse when the new divisor takes effect.
- `tick`, out, 1: one-cycle period pulse. Registered.
- `digit_sel`, out, 2: index of the active digit, 0..`DIGITS`-1.
- `anode`, out, `DIGITS`: anode enables, active-low.
- `blank`, out, 1: high while in the blanking state.

## Operation
- **Reset values:**
  - count = 0, div_active = max(`DIV_DEFAULT`, MIN_DIV), no pending divisor.
  - `tick` = 0, `cfg_ack` = 0.
  - State SHOW, `digit_sel` = 0, `anode` = all ones except bit 0 (4'b1110), `blank` = 0.
- **Clamp rule:** MIN_DIV = `BLANK_CYC` + 2. Any divisor below MIN_DIV, including 0 and 1, is clamped to MIN_DIV. No tick can arrive while the FSM is in BLANK.
- **Period counter:**
  - When `enable` = 1: count increments each cycle.
  - When count == div_active-1: count wraps to 0 and `tick` = 1 for the next cycle only.
  - When `enable` = 0: count, `tick` (held 0) and the FSM all hold.
- **Config handshake:**
  - With no divisor pending and `cfg_req` seen high, the block captures the clamped `cfg_div` into the pending register.
  - The pending divisor is applied at the next wrap edge, the same edge that raises `tick`. `cfg_ack` pulses for that one cycle.
  - If `enable` = 0, the pending divisor is applied on the next edge and count is forced to 0.
  - The requester drops `cfg_req` after `cfg_ack`. A new request is accepted only after `cfg_req` has been sampled low. While a divisor is pending, a held `cfg_req` is not re-captured.
- **Scan FSM:**
  - SHOW: `anode` = ~(1 << `digit_sel`), `blank` = 0. On `tick` = 1, move to BLANK.
  - BLANK: `anode` = all ones, `blank` = 1, internal counter runs `BLANK_CYC` cycles. On expiry, `digit_sel` = (`digit_sel` + 1) mod `DIGITS` and the FSM returns to SHOW.
- **Reset mid-operation:** any pending divisor is discarded. All registers return to their reset values asynchronously.

## Timing
- **Tick period:** with `enable` high from reset release, the first `tick` is high in the cycle after the `DIV_DEFAULT`-th rising edge. After that it repeats exactly every div_active cycles.
- **Divisor change:**
  - The old period completes in full.
  - The first period at the new divisor starts at the ack edge. The next `tick` comes new-div cycles after the `tick` that coincided with `cfg_ack`.
  - Request-to-ack latency ≤ old div_active + 1 cycles.
- **Scan:**
  - `anode` goes all-ones on the edge after `tick` is high.
  - The next digit's anode goes low `BLANK_CYC` cycles later.
  - `digit_sel` changes on that same edge.
- **Enable:** an `enable` deassert freezes all of these counts. They resume from the held values with no extra `tick`.

## Test plan
Common override: `DIV_DEFAULT` = 20, `BLANK_CYC` = 4, `DIGITS` = 4 (MIN_DIV = 6).
- **Reset, free run:** assert `rst` = 0, then release with `enable` = 1. Required: `anode` = 1110 and `tick` = 0 during reset; `tick` high after edges 20, 40 and 60, each for one cycle.
- **Scan sequence:** run 5 ticks. Required:
  - `anode` sequence 1110, 1111 (4 cycles), 1101, 1111, 1011, 1111, 0111, 1111, 1110.
  - `digit_sel` 0→1→2→3→0, with a wrap at 3.
- **Mid-period reprogram:** at count 7, `cfg_req` = 1 with `cfg_div` = 10. Required: `cfg_ack` pulses on edge 20 together with `tick`; subsequent ticks at 30 and 40.
- **Clamp:** request `cfg_div` = 3, then `cfg_div` = 0. Required: tick period 6 after each ack; the FSM never sees a tick while in BLANK.
- **Disabled config:** drop `enable` at count 12, then request `cfg_div` = 8. Required:
  - `cfg_ack` on the next edge, and count = 0.
  - No ticks while `enable` is low.
  - After re-enable, first tick at 8 cycles.
- **Reset mid-blank:** with a divisor pending, pull `rst` low during BLANK. Required:
  - `anode` = 1110 and `blank` = 0 immediately, with no clock edge.
  - After release: no `cfg_ack`, and the period is 20.
